regfile_banked: RTL
===================

REGFILE_BANKED -- requirements
Module: regfile_banked

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- DATA_W, 16, register width in bits
- NUM_GPR, 8, general-purpose registers per bank
- ADDR_W, 4, register address width; NUM_GPR+3 <= 2**ADDR_W
- RESET_PC, 0, PC value after reset
- STACK_BASE, 16'hFFFE, SP value after reset; empty-stack value
- STACK_LIMIT, 16'hF000, lowest legal SP value
- STACK_STEP, 2, SP change per push/pop

REQ-002 The block SHALL expose these ports (name direction width meaning):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- wr_en  in  1  GPR write enable
- rd_addr  in  ADDR_W  GPR write address
- rd_data  in  DATA_W  GPR write data
- pc_wr  in  1  load PC from pc_in
- pc_inc  in  1  advance PC by 2
- pc_in  in  DATA_W  PC load value
- sp_op  in  2  00 hold, 01 push, 10 pop, 11 load sp_in
- sp_in  in  DATA_W  SP load value
- flags_wr  in  1  load FLAGS from flags_in
- flags_in  in  DATA_W  FLAGS load value
- irq_enter  in  1  enter interrupt context
- irq_exit  in  1  return from interrupt context
- pc_out, sp_out, flags_out  out  DATA_W  current PC, SP, FLAGS
- in_irq  out  1  high while shadow bank active
- stack_err  out  1  sticky stack overflow/underflow flag

Function
REQ-003 Address map SHALL be: 0..NUM_GPR-1 GPRs of the active bank, NUM_GPR SP, NUM_GPR+1 PC, NUM_GPR+2 FLAGS; higher addresses read 0.
REQ-004 The block SHALL hold two GPR banks (bank 0 normal, bank 1 shadow); bank select register drives in_irq.
REQ-005 Reads SHALL be combinational; if wr_en=1 and rd_addr equals a read address in the GPR range, that port SHALL return rd_data (write bypass).
REQ-006 GPR writes SHALL occur only when wr_en=1 and rd_addr<NUM_GPR, into the bank active at the start of the cycle; writes to other addresses are ignored.
REQ-007 PC update priority SHALL be: irq_enter (PC<=RESET_PC-independent vector 0), then irq_exit (PC<=EPC), then pc_wr, then pc_inc (PC<=PC+2 mod 2**DATA_W).
REQ-008 FLAGS update priority SHALL be: irq_enter (FLAGS<=0), irq_exit (FLAGS<=saved FLAGS), flags_wr.
REQ-009 On irq_enter with in_irq=0, the block SHALL in one cycle copy PC to EPC, copy FLAGS to saved FLAGS, set bank select to 1.
REQ-010 On irq_exit with in_irq=1, the block SHALL in one cycle restore PC and FLAGS and set bank select to 0.
REQ-011 irq_enter while in_irq=1, irq_exit while in_irq=0, and irq_enter with irq_exit asserted together SHALL be ignored entirely (no state change from either).
REQ-012 Push SHALL set SP<=SP-STACK_STEP unless SP-STACK_STEP<STACK_LIMIT (unsigned, incl. wrap), in which case SP holds and stack_err sets.
REQ-013 Pop SHALL set SP<=SP+STACK_STEP unless SP>=STACK_BASE, in which case SP holds and stack_err sets.
REQ-014 sp_op=11 SHALL load sp_in unconditionally without range check; SP is shared by both banks.
REQ-015 stack_err SHALL remain set until reset.

Reset
REQ-016 When rst=1 at a rising edge, the block SHALL set all GPRs in both banks, FLAGS, EPC, saved FLAGS to 0, SP to STACK_BASE, PC to RESET_PC, bank select and stack_err to 0, overriding all other inputs that cycle.
REQ-017 Reset asserted while in_irq=1 SHALL return to bank 0 with no restore of PC/FLAGS.

Verification
REQ-018 Write r3=16'hBEEF with rs_addr=3 same cycle -> rs_data=16'hBEEF combinationally; next cycle without wr_en still 16'hBEEF.
REQ-019 r1=16'h1111 in bank 0, PC=16'h0040, FLAGS=16'h0005, pulse irq_enter, write r1=16'h2222, pulse irq_exit -> r1 reads 16'h1111, PC=16'h0040, FLAGS=16'h0005, in_irq 1 then 0.
REQ-020 After reset push -> SP=16'hFFFC, pop -> 16'hFFFE, pop again -> SP=16'hFFFE, stack_err=1 and stays 1.
REQ-021 sp_op=11 sp_in=16'hF000, push -> SP=16'hF000, stack_err=1.
REQ-022 pc_wr=1 pc_in=16'h0100 with pc_inc=1 -> PC=16'h0100; PC=16'hFFFE with pc_inc -> 16'h0000.
REQ-023 rst pulsed while in_irq=1 with wr_en=1 -> all GPRs 0, in_irq=0, PC=RESET_PC, SP=STACK_BASE.

Source files
------------

// File: rtl/regfile_banked.sv
// Banked register file: two GPR banks (normal/shadow), plus PC, SP, FLAGS.
// Interrupt entry/exit swaps banks and saves/restores PC and FLAGS in a single cycle.
module regfile_banked #(
  parameter int                DATA_W      = 16,
  parameter int                NUM_GPR     = 8,
  parameter int                ADDR_W      = 4,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] STACK_BASE  = 16'hFFFE,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hF000,
  parameter int                STACK_STEP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              pc_wr,
  input  logic              pc_inc,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [1:0]        sp_op,
  input  logic [DATA_W-1:0] sp_in,
  input  logic              flags_wr,
  input  logic [DATA_W-1:0] flags_in,
  input  logic              irq_enter,
  input  logic              irq_exit,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] sp_out,
  output logic [DATA_W-1:0] flags_out,
  output logic              in_irq,
  output logic              stack_err
);

  typedef enum logic {
    BANK_NORMAL = 1'b0,
    BANK_SHADOW = 1'b1
  } bank_e;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_LOAD = 2'b11
  } sp_op_e;

  localparam int                GPR_AW     = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
  localparam logic [ADDR_W-1:0] GPR_END    = ADDR_W'(NUM_GPR);
  localparam logic [ADDR_W-1:0] SP_ADDR    = ADDR_W'(NUM_GPR);
  localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(NUM_GPR + 1);
  localparam logic [ADDR_W-1:0] FLAGS_ADDR = ADDR_W'(NUM_GPR + 2);
  localparam logic [DATA_W-1:0] SP_STEP    = DATA_W'(STACK_STEP);
  localparam logic [DATA_W:0]   SP_STEP_X  = (DATA_W+1)'(STACK_STEP);

  // State
  bank_e             bank_q, bank_d;
  logic [DATA_W-1:0] gpr_q [2][NUM_GPR];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] flags_q, flags_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [DATA_W-1:0] sflags_q, sflags_d;
  logic              stack_err_q, stack_err_d;

  logic              bank_idx;
  logic              irq_take;
  logic              irq_ret;
  logic              gpr_wr;
  logic [DATA_W-1:0] rs_gpr;
  logic [DATA_W-1:0] rt_gpr;
  logic [DATA_W:0]   sp_dec;

  assign bank_idx = (bank_q == BANK_SHADOW);
  assign in_irq   = bank_idx;

  // Illegal or conflicting interrupt requests collapse to "no request".
  assign irq_take = irq_enter && !irq_exit && (bank_q == BANK_NORMAL);
  assign irq_ret  = irq_exit && !irq_enter && (bank_q == BANK_SHADOW);

  assign gpr_wr   = wr_en && (rd_addr < GPR_END);

  // Read path: active-bank GPR with same-cycle write bypass, then address map.
  assign rs_gpr = (wr_en && (rd_addr == rs_addr)) ? rd_data
                                                  : gpr_q[bank_idx][rs_addr[GPR_AW-1:0]];
  assign rt_gpr = (wr_en && (rd_addr == rt_addr)) ? rd_data
                                                  : gpr_q[bank_idx][rt_addr[GPR_AW-1:0]];

  function automatic logic [DATA_W-1:0] port_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] gpr_val,
    input logic [DATA_W-1:0] sp,
    input logic [DATA_W-1:0] pc,
    input logic [DATA_W-1:0] flags
  );
    if (addr < GPR_END)          return gpr_val;
    else if (addr == SP_ADDR)    return sp;
    else if (addr == PC_ADDR)    return pc;
    else if (addr == FLAGS_ADDR) return flags;
    else                         return '0;
  endfunction

  assign rs_data   = port_read(rs_addr, rs_gpr, sp_q, pc_q, flags_q);
  assign rt_data   = port_read(rt_addr, rt_gpr, sp_q, pc_q, flags_q);
  assign pc_out    = pc_q;
  assign sp_out    = sp_q;
  assign flags_out = flags_q;
  assign stack_err = stack_err_q;

  // Bank-select FSM next state.
  always_comb begin
    bank_d = bank_q;
    if (irq_take)     bank_d = BANK_SHADOW;
    else if (irq_ret) bank_d = BANK_NORMAL;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d     = pc_q;
    flags_d  = flags_q;
    epc_d    = epc_q;
    sflags_d = sflags_q;

    if (irq_take)     pc_d = '0;
    else if (irq_ret) pc_d = epc_q;
    else if (pc_wr)   pc_d = pc_in;
    else if (pc_inc)  pc_d = pc_q + DATA_W'(2);

    if (irq_take)      flags_d = '0;
    else if (irq_ret)  flags_d = sflags_q;
    else if (flags_wr) flags_d = flags_in;

    if (irq_take) begin
      epc_d    = pc_q;
      sflags_d = flags_q;
    end
  end

  // Stack pointer: bounded push/pop with a sticky error, unchecked load.
  assign sp_dec = {1'b0, sp_q} - SP_STEP_X;

  always_comb begin
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    unique case (sp_op_e'(sp_op))
      SP_PUSH: begin
        if (sp_dec[DATA_W] || (sp_dec[DATA_W-1:0] < STACK_LIMIT)) stack_err_d = 1'b1;
        else                                                      sp_d        = sp_dec[DATA_W-1:0];
      end
      SP_POP: begin
        if (sp_q >= STACK_BASE) stack_err_d = 1'b1;
        else                    sp_d        = sp_q + SP_STEP;
      end
      SP_LOAD: sp_d = sp_in;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= BANK_NORMAL;
      pc_q        <= RESET_PC;
      sp_q        <= STACK_BASE;
      flags_q     <= '0;
      epc_q       <= '0;
      sflags_q    <= '0;
      stack_err_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      flags_q     <= flags_d;
      epc_q       <= epc_d;
      sflags_q    <= sflags_d;
      stack_err_q <= stack_err_d;
    end
  end

  // NOTE: the GPR banks must read zero after reset, so they are built from resettable flops, not RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_GPR; i++) begin
          gpr_q[b][i] <= '0;
        end
      end
    end else if (gpr_wr) begin
      gpr_q[bank_idx][rd_addr[GPR_AW-1:0]] <= rd_data;
    end
  end

endmodule
